// File: rtl/mul_pkg.sv
// ============================================================================
// mul_pkg: shared types and constants for the sequential unsigned multiplier.
// Rev 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MUL_WIDTH_DEFAULT = 32;

   // Counter must reach WIDTH-1 and still be able to hold the wrap to WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_unsigned_multiplier_if.sv
// ============================================================================
// seq_unsigned_multiplier_if: run/rdy operand and product bundle.
// Optional ovf signal exists only when MUL_OVERFLOW_FLAG_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

interface seq_unsigned_multiplier_if
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
);

   logic                 run;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [2*WIDTH-1:0]   product;
   logic                 rdy;
`ifdef MUL_OVERFLOW_FLAG_EN
   logic                 ovf;

   modport master (output run, multiplicand, multiplier, input product, rdy, ovf);
   modport slave  (input run, multiplicand, multiplier, output product, rdy, ovf);
`else
   modport master (output run, multiplicand, multiplier, input product, rdy);
   modport slave  (input run, multiplicand, multiplier, output product, rdy);
`endif

endinterface

`default_nettype wire

// File: rtl/mul_control.sv
// ============================================================================
// mul_control: IDLE/ITER/DONE sequencer and iteration counter for the multiplier.
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_control
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
)
(
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic load,
   output logic step,
   output logic rdy,
   output logic done
);

   localparam int            CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      load        = 1'b0;
      step        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (run) begin
               load        = 1'b1;
               w_count_nxt = '0;
               w_state_nxt = ITER;
            end
         end
         ITER: begin
            if (run) begin
               step        = 1'b1;
               w_count_nxt = r_count + 1'b1;
               if (r_count == C_LAST) begin
                  done        = 1'b1;
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (!run) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // rdy is exactly "sitting in DONE": set on the entering edge, cleared on exit.
   assign rdy = (r_state == DONE);

endmodule

`default_nettype wire

// File: rtl/seq_unsigned_multiplier.sv
// ============================================================================
// seq_unsigned_multiplier: shift-add WIDTH x WIDTH -> 2*WIDTH, one bit per clock.
// Optional overflow flag via MUL_OVERFLOW_FLAG_EN. Rev 1.0
// ============================================================================
`default_nettype none

module seq_unsigned_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
)
(
   input  logic                        clk,
   input  logic                        rst,
   seq_unsigned_multiplier_if.slave    bus
);

   logic               w_load;
   logic               w_step;
   logic               w_rdy;
   logic               w_done;

   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_acc_shift;

   mul_control #(
      .WIDTH (WIDTH)
   ) u_ctrl (
      .clk  (clk),
      .rst  (rst),
      .run  (bus.run),
      .load (w_load),
      .step (w_step),
      .rdy  (w_rdy),
      .done (w_done)
   );

   // The carry bit of the accumulator only ever lives in w_sum: the right
   // shift moves it into hi[WIDTH-1] on the same edge, so it is never stored.
   assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand <= '0;
         r_acc   <= '0;
      end else if (w_load) begin
         r_mcand <= bus.multiplicand;
         r_acc   <= {{WIDTH{1'b0}}, bus.multiplier};
      end else if (w_step) begin
         r_acc   <= w_acc_shift;
      end
   end

   assign bus.product = r_acc;
   assign bus.rdy     = w_rdy;

`ifdef MUL_OVERFLOW_FLAG_EN
   logic r_ovf;

   always_ff @(posedge clk) begin
      if (rst || w_load) begin
         r_ovf <= 1'b0;
      end else if (w_done) begin
         r_ovf <= (w_acc_shift[2*WIDTH-1:WIDTH] != '0);
      end
   end

   assign bus.ovf = r_ovf;
`else
   logic w_unused_done;
   assign w_unused_done = w_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_unsigned_multiplier.sv
// ============================================================================
// tb_seq_unsigned_multiplier: table-driven scoreboard bench for 32- and 8-bit builds.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_unsigned_multiplier;

   localparam int W  = 32;
   localparam int W8 = 8;
   localparam int NV = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   seq_unsigned_multiplier_if #(.WIDTH(W))  bus  ();
   seq_unsigned_multiplier_if #(.WIDTH(W8)) bus8 ();

   seq_unsigned_multiplier #(.WIDTH(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   seq_unsigned_multiplier #(.WIDTH(W8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] prod;
      int          hold_at;
      int          hold_len;
      bit          toggle;
   } vec_t;

   vec_t        vecs [NV];
   logic [63:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, req);
      end
   endtask

   // One full transaction: capture, wait for rdy (bounded), compare, then release.
   task automatic run_vec(input vec_t v);
      int          cyc;
      logic [63:0] e_prod;
      exp_q.push_back(v.prod);
      @(negedge clk);
      bus.run          = 1'b1;
      bus.multiplicand = v.a;
      bus.multiplier   = v.b;
      @(posedge clk);
      cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         if (bus.rdy) break;
         if (v.toggle) begin
            bus.multiplicand = $urandom;
            bus.multiplier   = $urandom;
         end
         if (v.hold_len > 0 && cyc == v.hold_at)              bus.run = 1'b0;
         if (v.hold_len > 0 && cyc == v.hold_at + v.hold_len) bus.run = 1'b1;
         @(posedge clk);
         cyc++;
      end
      e_prod = exp_q.pop_front();
      check64("latency", 64'(cyc), 64'(W + v.hold_len));
      check64("product", bus.product, e_prod);
`ifdef MUL_OVERFLOW_FLAG_EN
      check64("ovf", 64'(bus.ovf), 64'(e_prod[63:32] != 32'd0));
`endif
      bus.run = 1'b0;
      @(posedge clk);
      #1;
      check64("rdy_fall", 64'(bus.rdy), 64'd0);
      check64("product_hold", bus.product, e_prod);
   endtask

   vec_t v79;
   logic [7:0]  a8 [2];
   logic [7:0]  b8 [2];
   logic [15:0] p8 [2];

   initial begin
      int cyc;
      bus.run   = 1'b0; bus.multiplicand  = '0; bus.multiplier  = '0;
      bus8.run  = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0;

      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 0,  0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 0,  0, 1'b0};
      vecs[2] = '{32'h1234_5678,  32'h9ABC_DEF0,  64'h0B00_EA4E_242D_2080, 10, 5, 1'b0};
      vecs[3] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 0,  0, 1'b1};
      vecs[4] = '{32'h0000_0000,  32'hDEAD_BEEF,  64'h0000_0000_0000_0000, 0,  0, 1'b1};
      vecs[5] = '{32'h0000_0001,  32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, 0,  0, 1'b0};
      vecs[6] = '{32'h8000_0000,  32'h0000_0002,  64'h0000_0001_0000_0000, 0,  0, 1'b0};
      for (int i = 7; i < NV; i++) begin
         vecs[i].a        = $urandom;
         vecs[i].b        = $urandom;
         vecs[i].prod     = 64'(vecs[i].a) * 64'(vecs[i].b);
         vecs[i].hold_at  = 3 + i;
         vecs[i].hold_len = i - 6;
         vecs[i].toggle   = 1'b1;
      end
      v79 = '{32'd7, 32'd9, 64'd63, 0, 0, 1'b0};
      a8[0] = 8'd3;   b8[0] = 8'd5;   p8[0] = 16'h000F;
      a8[1] = 8'hFF;  b8[1] = 8'hFF;  p8[1] = 16'hFE01;

      repeat (3) @(posedge clk);
      #1;
      check64("reset_rdy", 64'(bus.rdy), 64'd0);
      check64("reset_product", bus.product, 64'd0);
      check64("reset_product8", 64'(bus8.product), 64'd0);
`ifdef MUL_OVERFLOW_FLAG_EN
      check64("reset_ovf", 64'(bus.ovf), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Reset in the middle of an operation must wipe every visible result.
      @(negedge clk);
      bus.run = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd9;
      @(posedge clk);
      repeat (16) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check64("midrst_rdy", 64'(bus.rdy), 64'd0);
      check64("midrst_product", bus.product, 64'd0);
      @(negedge clk);
      rst = 1'b0; bus.run = 1'b0;
      run_vec(v79);

      // rst and run together: reset wins, nothing is captured.
      @(negedge clk);
      rst = 1'b1; bus.run = 1'b1; bus.multiplicand = 32'd3; bus.multiplier = 32'h55;
      @(posedge clk);
      #1;
      check64("rstrun_product", bus.product, 64'd0);
      @(negedge clk);
      rst = 1'b0; bus.run = 1'b0;
      @(posedge clk);
      #1;
      check64("rstrun_idle_product", bus.product, 64'd0);
      check64("rstrun_idle_rdy", 64'(bus.rdy), 64'd0);
      run_vec(v79);

      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         bus8.run = 1'b1; bus8.multiplicand = a8[k]; bus8.multiplier = b8[k];
         @(posedge clk);
         cyc = 0;
         while (cyc < 50) begin
            @(negedge clk);
            if (bus8.rdy) break;
            @(posedge clk);
            cyc++;
         end
         check64("w8_latency", 64'(cyc), 64'(W8));
         check64("w8_product", 64'(bus8.product), 64'(p8[k]));
`ifdef MUL_OVERFLOW_FLAG_EN
         check64("w8_ovf", 64'(bus8.ovf), 64'(p8[k][15:8] != 8'd0));
`endif
         bus8.run = 1'b0;
         @(posedge clk);
         #1;
         check64("w8_rdy_fall", 64'(bus8.rdy), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
